// File: rtl/ex_div_ctrl.sv
// RV32M divide sequencer: one DIV/DIVU/REM/REMU at a time, radix-2 restoring
// divide over XLEN cycles, RISC-V special cases resolved in one cycle.
module ex_div_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic            reg_we_o,
  output logic [4:0]      reg_waddr_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_END} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   rem_q, quo_q, dvs_q, result_q;
  logic              rem_op_q, neg_quo_q, neg_rem_q, ready_q;
  logic [4:0]        waddr_q;

  // Operand decode on the accept cycle; funct3 values outside 110/100/111 act as DIVU
  logic            in_signed, in_rem, dvd_neg, dvs_neg, div_zero, ovf, special, accept;
  logic [XLEN-1:0] dvd_abs, dvs_abs, special_res;

  always_comb begin
    in_signed   = (op_i == 3'b100) || (op_i == 3'b110);
    in_rem      = (op_i == 3'b110) || (op_i == 3'b111);
    dvd_neg     = in_signed & dividend_i[XLEN-1];
    dvs_neg     = in_signed & divisor_i[XLEN-1];
    dvd_abs     = dvd_neg ? -dividend_i : dividend_i;
    dvs_abs     = dvs_neg ? -divisor_i  : divisor_i;
    div_zero    = (divisor_i == '0);
    ovf         = in_signed && (dividend_i == MIN_NEG) && (divisor_i == '1);
    special     = div_zero | ovf;
    accept      = (state_q == S_IDLE) & start_i & ~flush_i;
    special_res = div_zero ? (in_rem ? dividend_i : '1)
                           : (in_rem ? '0 : MIN_NEG);
  end

  // One restoring step: shift {rem,quo}, try subtracting the divisor magnitude
  logic [XLEN:0]   rem_sh, trial;
  logic [XLEN-1:0] rem_n, quo_n, calc_res;
  logic            last;

  always_comb begin
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    trial    = rem_sh - {1'b0, dvs_q};
    rem_n    = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
    quo_n    = {quo_q[XLEN-2:0], ~trial[XLEN]};
    last     = (cnt_q == CNT_W'(XLEN-1));
    calc_res = rem_op_q ? (neg_rem_q ? -rem_n : rem_n)
                        : (neg_quo_q ? -quo_n : quo_n);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state; a flush returns to IDLE from anywhere
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = special ? S_END : S_CALC;
      S_CALC:  if (last)   state_d = S_END;
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  // Datapath: latch on accept, iterate in CALC, register the result on END entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      rem_op_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      waddr_q   <= '0;
    end else begin
      ready_q <= (state_d == S_END);
      if (accept) begin
        cnt_q     <= '0;
        rem_q     <= '0;
        quo_q     <= dvd_abs;
        dvs_q     <= dvs_abs;
        rem_op_q  <= in_rem;
        neg_quo_q <= dvd_neg ^ dvs_neg;
        neg_rem_q <= dvd_neg;
        waddr_q   <= reg_waddr_i;
        if (special) result_q <= special_res;
      end else if (state_q == S_CALC) begin
        cnt_q <= cnt_q + CNT_W'(1);
        rem_q <= rem_n;
        quo_q <= quo_n;
        if (last) result_q <= calc_res;
      end
    end
  end

  // Stall holds execute on the accept cycle and through CALC, never in END
  assign stall_o     = accept | ((state_q == S_CALC) & ~flush_i);
  assign busy_o      = (state_q != S_IDLE);
  assign ready_o     = ready_q & ~flush_i;
  assign reg_we_o    = ready_q & ~flush_i;
  assign result_o    = result_q;
  assign reg_waddr_o = waddr_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Bench for ex_div_ctrl: directed plan steps plus randomized ops, each checked
// against an arithmetic RV32M reference model.
module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i, divisor_i;
  logic [4:0]  reg_waddr_i;
  logic        stall_o, busy_o, ready_o, reg_we_o;
  logic [31:0] result_o;
  logic [4:0]  reg_waddr_o;

  int n_tests = 0;
  int n_fail  = 0;

  ex_div_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .reg_waddr_i(reg_waddr_i),
    .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o), .result_o(result_o),
    .ready_o(ready_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sgn = (op == 3'b100) || (op == 3'b110);
    return (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V M-extension semantics written as plain arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sgn = (op == 3'b100) || (op == 3'b110);
    bit rem = (op == 3'b110) || (op == 3'b111);
    int sa = a;
    int sb = b;
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    if (sgn) return rem ? (sa % sb) : (sa / sb);
    return rem ? (a % b) : (a / b);
  endfunction

  // Issue one op, follow it to its write-back and check timing and result.
  // poke>0 pulses start_i with junk on that busy cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int poke);
    logic [31:0] exp = ref_res(op, a, b);
    int exp_lat = is_special(op, a, b) ? 1 : 33;
    int lat = 0;
    int stalls = 0;
    bit seen = 0;
    @(negedge clk);
    start_i = 1; op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = rd;
    #1;
    if (stall_o) stalls++;
    @(posedge clk); #1;
    start_i = 0; dividend_i = $urandom; divisor_i = $urandom; reg_waddr_i = 5'($urandom);
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (ready_o) begin
        seen = 1; lat = k;
      end else begin
        if (stall_o) stalls++;
        start_i = (k == poke);
        @(posedge clk); #1;
      end
    end
    start_i = 0;
    chk("latency", lat, exp_lat);
    chk("stall_cycles", stalls, exp_lat);
    chk("result", result_o, exp);
    chk("reg_we", {31'b0, reg_we_o}, 32'd1);
    chk("waddr", {27'b0, reg_waddr_o}, {27'b0, rd});
    chk("stall_in_end", {31'b0, stall_o}, 32'd0);
    chk("busy_in_end", {31'b0, busy_o}, 32'd1);
    @(posedge clk); #1;
    chk("ready_drop", {31'b0, ready_o}, 32'd0);
    chk("idle_after", {31'b0, busy_o}, 32'd0);
    chk("result_hold", result_o, exp);
  endtask

  initial begin
    int rdy_seen;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst = 0; start_i = 0; flush_i = 0; op_i = 0;
    dividend_i = 0; divisor_i = 0; reg_waddr_i = 0;
    #1;
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_ready", {31'b0, ready_o}, 32'd0);
    chk("rst_we", {31'b0, reg_we_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_waddr", {27'b0, reg_waddr_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1;

    // Directed plan
    run_op(3'b101, 32'd100, 32'd7, 5'd5, 0);
    run_op(3'b100, -32'sd100, 32'd7, 5'd6, 0);
    run_op(3'b110, -32'sd100, 32'd7, 5'd7, 0);
    run_op(3'b111, 32'hFFFF_FFFF, 32'h10, 5'd8, 0);
    run_op(3'b100, 32'h1234, 32'd0, 5'd9, 0);
    run_op(3'b110, 32'h1234, 32'd0, 5'd10, 0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);

    // Flush at CALC cycle 10
    @(negedge clk);
    start_i = 1; op_i = 3'b101; dividend_i = 32'd1000; divisor_i = 32'd3; reg_waddr_i = 5'd13;
    @(posedge clk); #1; start_i = 0;
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk); flush_i = 1; #1;
    chk("flush_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1; flush_i = 0;
    chk("flush_idle", {31'b0, busy_o}, 32'd0);
    rdy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready_o || reg_we_o) rdy_seen++;
      @(posedge clk); #1;
    end
    chk("flush_no_wb", rdy_seen, 0);

    // start with flush in IDLE is not accepted
    @(negedge clk); start_i = 1; flush_i = 1; #1;
    chk("sf_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1; start_i = 0; flush_i = 0;
    chk("sf_busy", {31'b0, busy_o}, 32'd0);
    run_op(3'b101, 32'd9, 32'd3, 5'd14, 0);

    // start while busy is ignored; then back-to-back ops
    run_op(3'b100, 32'd12345, -32'sd77, 5'd15, 5);
    run_op(3'b111, 32'd98765, 32'd1000, 5'd16, 0);
    run_op(3'b101, 32'hDEAD_BEEF, 32'd3, 5'd17, 0);

    // Reset mid-CALC
    @(negedge clk);
    start_i = 1; op_i = 3'b101; dividend_i = 32'hFFFF; divisor_i = 32'd3; reg_waddr_i = 5'd18;
    @(posedge clk); #1; start_i = 0;
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk); rst = 0; #1;
    chk("mrst_stall", {31'b0, stall_o}, 32'd0);
    chk("mrst_busy", {31'b0, busy_o}, 32'd0);
    chk("mrst_ready", {31'b0, ready_o}, 32'd0);
    chk("mrst_we", {31'b0, reg_we_o}, 32'd0);
    chk("mrst_result", result_o, 32'd0);
    chk("mrst_waddr", {27'b0, reg_waddr_o}, 32'd0);
    @(negedge clk); rst = 1;
    run_op(3'b101, 32'd1, 32'd1, 5'd19, 0);

    // Randomized ops with biased corner operands
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 20);
        3: rb = -$urandom_range(1, 20);
        default: ;
      endcase
      run_op(rop, ra, rb, 5'($urandom), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
